// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts consecutive wait-state ACCESS cycles and flags the last one allowed
// before the master must abort. Only instantiated with APB_TIMEOUT_EN.
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // tc marks the cycle in which one more low PREADY exhausts the budget
    assign tc = (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester: sequences valid/ready commands through SETUP/ACCESS and
// returns a one-cycle response. Optional wait-state abort with APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    apb_state_e state, state_next;
    logic       accept;
    logic       complete;
    logic       abort;

    assign cmd_ready = (state == IDLE) || (state == ACCESS && PREADY);
    assign accept    = cmd_valid && cmd_ready;
    assign complete  = (state == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
    logic tc;
    logic err_q;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (state == SETUP),
        .inc    ((state == ACCESS) && !PREADY),
        .tc     (tc)
    );

    // A PREADY arriving on the limit edge is a normal completion
    assign abort = (state == ACCESS) && !PREADY && tc;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_q <= 1'b0;
        end else if (complete) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    assign abort = 1'b0;
    // TIMEOUT_CYCLES has no effect in this build
    assign rsp_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_next = accept ? SETUP : IDLE;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they track it exactly
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_next;
            PSEL      <= (state_next != IDLE);
            PENABLE   <= (state_next == ACCESS);
            rsp_valid <= complete || abort;
            if (accept) begin
                PWRITE <= cmd_write;
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
            end
            if (complete) begin
                rsp_rdata <= PWRITE ? '0 : PRDATA;
            end else if (abort) begin
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master; timeout cases run when APB_TIMEOUT_EN is defined.
module tb_apb_master;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    int checkCount = 0;
    int errorCount = 0;

    apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        PRESETn = 1'b0;
        PREADY  = 1'b1;
        PRDATA  = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset values
        tick();
        tick();
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        #4 PRESETn = 1'b1;

        // Write, zero wait states
        tick();
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1 checkOutput("wr_cmd_ready_idle", cmd_ready, 1);
        tick();
        checkOutput("wr_setup_psel", PSEL, 1);
        checkOutput("wr_setup_penable", PENABLE, 0);
        checkOutput("wr_setup_cmd_ready", cmd_ready, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("wr_access_penable", PENABLE, 1);
        checkOutput("wr_access_paddr", PADDR, 32'h10);
        checkOutput("wr_access_pwdata", PWDATA, 32'hDEADBEEF);
        checkOutput("wr_access_pwrite", PWRITE, 1);
        checkOutput("wr_access_rsp_valid", rsp_valid, 0);
        tick();
        checkOutput("wr_done_psel", PSEL, 0);
        checkOutput("wr_done_rsp_valid", rsp_valid, 1);
        checkOutput("wr_done_rsp_rdata", rsp_rdata, 0);
        checkOutput("wr_done_rsp_err", rsp_err, 0);
        checkOutput("wr_idle_paddr_hold", PADDR, 32'h10);
        tick();
        checkOutput("wr_rsp_one_cycle", rsp_valid, 0);

        // Read with three wait states; PRDATA ignored until the completing edge
        applyStimulus(1'b1, 1'b0, 32'h20, 32'hFFFFFFFF);
        PREADY = 1'b0;
        PRDATA = 32'hBAD0BAD0;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rd_w1_penable", PENABLE, 1);
        checkOutput("rd_w1_paddr", PADDR, 32'h20);
        checkOutput("rd_w1_cmd_ready", cmd_ready, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rd_wait_psel", PSEL, 1);
            checkOutput("rd_wait_paddr", PADDR, 32'h20);
            checkOutput("rd_wait_rsp_valid", rsp_valid, 0);
        end
        tick();
        checkOutput("rd_w4_penable", PENABLE, 1);
        checkOutput("rd_w4_paddr", PADDR, 32'h20);
        PREADY = 1'b1;
        PRDATA = 32'h12345678;
        tick();
        checkOutput("rd_done_rsp_valid", rsp_valid, 1);
        checkOutput("rd_done_rsp_rdata", rsp_rdata, 32'h12345678);
        checkOutput("rd_done_psel", PSEL, 0);
        tick();

        // Back-to-back write then read
        applyStimulus(1'b1, 1'b1, 32'h4, 32'hA5A5A5A5);
        tick();
        checkOutput("b2b_setup1_paddr", PADDR, 32'h4);
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0);
        PRDATA = 32'h0BADF00D;
        tick();
        checkOutput("b2b_access1_penable", PENABLE, 1);
        checkOutput("b2b_access1_paddr", PADDR, 32'h4);
        checkOutput("b2b_access1_cmd_ready", cmd_ready, 1);
        tick();
        checkOutput("b2b_setup2_psel", PSEL, 1);
        checkOutput("b2b_setup2_penable", PENABLE, 0);
        checkOutput("b2b_setup2_paddr", PADDR, 32'h8);
        checkOutput("b2b_setup2_pwrite", PWRITE, 0);
        checkOutput("b2b_rsp1_valid", rsp_valid, 1);
        checkOutput("b2b_rsp1_rdata", rsp_rdata, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        PRDATA = 32'hCAFEF00D;
        tick();
        checkOutput("b2b_access2_psel", PSEL, 1);
        checkOutput("b2b_access2_rsp_valid", rsp_valid, 0);
        tick();
        checkOutput("b2b_rsp2_valid", rsp_valid, 1);
        checkOutput("b2b_rsp2_rdata", rsp_rdata, 32'hCAFEF00D);
        checkOutput("b2b_idle_psel", PSEL, 0);
        tick();

        // Reset during a stalled ACCESS
        applyStimulus(1'b1, 1'b1, 32'h30, 32'h11112222);
        PREADY = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rst_mid_access_psel", PSEL, 1);
        #2 PRESETn = 1'b0;
        #1;
        checkOutput("rst_mid_psel", PSEL, 0);
        checkOutput("rst_mid_penable", PENABLE, 0);
        checkOutput("rst_mid_rsp_valid", rsp_valid, 0);
        checkOutput("rst_mid_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_mid_paddr", PADDR, 0);
        #1 PRESETn = 1'b1;
        PREADY = 1'b1;
        #1 checkOutput("rst_rel_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_rel_no_rsp", rsp_valid, 0);
            checkOutput("rst_rel_psel", PSEL, 0);
        end

`ifdef APB_TIMEOUT_EN
        // Timeout: four low-PREADY ACCESS cycles abort the transfer
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
        PREADY = 1'b0;
        PRDATA = 32'h77777777;
        tick();
        applyStimulus(1'b1, 1'b1, 32'h44, 32'h99998888);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("to_wait_penable", PENABLE, 1);
            checkOutput("to_wait_cmd_ready", cmd_ready, 0);
        end
        tick();
        checkOutput("to_abort_psel", PSEL, 0);
        checkOutput("to_abort_rsp_valid", rsp_valid, 1);
        checkOutput("to_abort_rsp_err", rsp_err, 1);
        checkOutput("to_abort_rsp_rdata", rsp_rdata, 0);
        PREADY = 1'b1;
        tick();
        checkOutput("to_next_setup_paddr", PADDR, 32'h44);
        checkOutput("to_next_rsp_valid", rsp_valid, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("to_next_rsp_valid2", rsp_valid, 1);
        checkOutput("to_next_rsp_err", rsp_err, 0);
        tick();

        // Tie: PREADY rises on the edge the limit is reached
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0);
        PREADY = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        checkOutput("tie_w4_penable", PENABLE, 1);
        PREADY = 1'b1;
        PRDATA = 32'h5A5A0001;
        tick();
        checkOutput("tie_rsp_valid", rsp_valid, 1);
        checkOutput("tie_rsp_err", rsp_err, 0);
        checkOutput("tie_rsp_rdata", rsp_rdata, 32'h5A5A0001);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester that sits directly upstream of the team's APB slaves. Accepts single read/write commands on a valid/ready command port and sequences them through the APB IDLE -> SETUP -> ACCESS protocol. Waits on PREADY and returns read data (or write completion) on a one-cycle response strobe. Supports back-to-back transfers with no intervening IDLE cycle.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr / PADDR
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, consecutive PREADY-low ACCESS cycles before abort (used only with APB_TIMEOUT_EN)

Ports:
PCLK  in  1  single clock; all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and aborted transfers
rsp_err  out  1  transfer aborted by timeout; valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready / wait-state control

Behaviour:
- Reset (asynchronous, PRESETn low): state = IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0. Reset mid-transfer drops the transfer silently and produces no response.
- States: IDLE, SETUP, ACCESS. Both APB and response outputs are registered.
- cmd_ready = (state == IDLE) || (state == ACCESS && PREADY). It is combinational from state and PREADY, and is never asserted during SETUP.
- IDLE: PSEL=0, PENABLE=0. On accept, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, then go to SETUP.
- SETUP: exactly one cycle with PSEL=1, PENABLE=0, then go to ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: transfer completes at this edge.
    - Next cycle: rsp_valid=1.
    - rsp_rdata = PRDATA sampled at this edge for reads, 0 for writes.
    - rsp_err = 0.
    - If a new command is accepted at the same edge, go to SETUP with the new command latched (back-to-back); otherwise go to IDLE.
- PADDR/PWRITE/PWDATA hold stable from SETUP through the final ACCESS cycle. They also hold their last values in IDLE; only PSEL/PENABLE drop.
- rsp_valid is high for exactly one cycle per completed or aborted transfer. rsp_rdata/rsp_err remain stable until the next response.
- Latency, zero wait states:
  - Accept at edge N; SETUP in cycle N..N+1; ACCESS in cycle N+1..N+2.
  - Completion at edge N+2; rsp_valid high in cycle after edge N+2.
  - Each wait state adds 1 cycle.
- Back-to-back throughput: one transfer per 2 cycles.
- PRDATA is ignored outside the completing ACCESS edge, and for writes.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When TIMEOUT_CYCLES consecutive PREADY-low ACCESS cycles have elapsed, the master aborts at that edge.
  - On abort: go to IDLE (PSEL=PENABLE=0 next cycle), pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - cmd_ready is not asserted on the abort edge.
  - If PREADY=1 on the same edge the limit is reached, normal completion wins and rsp_err=0.
- Undefined: no counter is instantiated, the master waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Shared package apb_pkg: state typedef enum logic [1:0] {IDLE, SETUP, ACCESS}; default width localparams (APB_ADDR_W = 32, APB_DATA_W = 32).
- One natural sub-module, apb_wait_timer: counter plus terminal-count flag, instantiated only under APB_TIMEOUT_EN. Everything else stays in apb_master.

Test Plan:
- Write, zero wait: cmd write addr 0x10 data 0xDEADBEEF, PREADY=1 -> one SETUP cycle, one ACCESS cycle with PADDR=0x10 and PWDATA=0xDEADBEEF; rsp_valid 1 cycle after completion, rsp_rdata=0, rsp_err=0.
- Read, 3 wait states: cmd read addr 0x20; PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR stable for all 4 ACCESS cycles; rsp_rdata=0x12345678.
- Back-to-back: cmd_valid held with write 0x4 then read 0x8, PREADY=1 -> second SETUP directly follows first ACCESS; PSEL never drops between; two rsp_valid pulses 2 cycles apart.
- Reset mid-ACCESS: assert PRESETn low during a PREADY-low ACCESS -> PSEL, PENABLE, rsp_valid go 0 immediately; after release, state is IDLE, cmd_ready=1, no response emitted.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY held 0 -> abort after 4 ACCESS cycles; rsp_valid=1, rsp_err=1, rsp_rdata=0; next command proceeds normally.
- Timeout tie (APB_TIMEOUT_EN): PREADY rises on the 4th wait cycle edge -> normal completion, rsp_err=0.
